// File: rtl/mult_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_sequencer_pkg
// Description : Shared definitions for the sequential signed multiplier:
//               FSM state encoding, operand width, iteration count and a
//               two's-complement magnitude helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_sequencer_pkg;

  localparam int c_WIDTH      = 32;
  localparam int c_ITER_COUNT = 32;
  localparam int c_CNT_W      = 5;

  // Last counter value seen in ITER before moving on to FIX.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITER_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Unsigned magnitude of a signed operand. -2^31 maps onto 32'h8000_0000,
  // which is the correct unsigned magnitude, so no overflow handling is needed.
  function automatic logic [c_WIDTH-1:0] f_magnitude(input logic [c_WIDTH-1:0] v);
    return v[c_WIDTH-1] ? ((~v) + {{(c_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage : mult_sequencer_pkg
`default_nettype wire

// File: rtl/rc_add_sub_32.sv
`default_nettype none
// ============================================================================
// Module      : rc_add_sub_32
// Description : 32-bit ripple-carry adder/subtractor.
//               i_a, i_b : operands
//               i_sub    : 0 = a + b, 1 = a - b (b inverted, carry-in = 1)
//               o_sum    : 32-bit result
//               o_cout   : carry out of bit 31
// Revision    : 1.0 - initial release
// ============================================================================
module rc_add_sub_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [32:0] w_c;
  logic [31:0] w_b;

  assign w_c[0] = i_sub;
  assign w_b    = i_b ^ {32{i_sub}};

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      assign o_sum[gi]  = i_a[gi] ^ w_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (i_a[gi] & w_b[gi]) | (w_c[gi] & (i_a[gi] ^ w_b[gi]));
    end
  endgenerate

  assign o_cout = w_c[32];

endmodule : rc_add_sub_32
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mult_sequencer
// Description : Sequential signed 32x32 -> 64 shift-and-add multiplier.
//               Operands are converted to magnitudes, multiplied over 32
//               iterations, then the sign is re-applied.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   start        : begin a multiply (accepted in IDLE or DONE only)
//   multiplicand : signed operand A, captured on accept
//   multiplier   : signed operand B, captured on accept
//   busy         : high in LOAD, ITER and FIX
//   done         : one-cycle pulse, product valid
//   product      : signed 64-bit result, updated only in FIX
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = c_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_mag_a;
  logic [2*WIDTH-1:0]   r_p;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_sign;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_p_next;

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Upper half of P plus |A|; the carry becomes bit 64 before the shift.
  rc_add_sub_32 u_add (
    .i_a    (r_p[2*WIDTH-1:WIDTH]),
    .i_b    (r_mag_a),
    .i_sub  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // One shift-and-add step: {carry, P} (after optional add) shifted right by one.
  assign w_p_next = r_p[0] ? {w_cout, w_sum, r_p[WIDTH-1:1]}
                           : {1'b0, r_p[2*WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        busy   = 1'b1;
        w_next = ST_ITER;
      end
      ST_ITER: begin
        busy = 1'b1;
        if (r_cnt == c_CNT_LAST) w_next = ST_FIX;
      end
      ST_FIX: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = w_accept ? ST_LOAD : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mag_a <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      product <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= multiplicand;
        r_b    <= multiplier;
        r_sign <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
      end
      case (r_state)
        ST_LOAD: begin
          r_mag_a <= f_magnitude(r_a);
          r_p     <= {{WIDTH{1'b0}}, f_magnitude(r_b)};
          r_cnt   <= '0;
        end
        ST_ITER: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          product <= r_sign ? ((~r_p) + {{(2*WIDTH-1){1'b0}}, 1'b1}) : r_p;
        end
        default: ;
      endcase
    end
  end

endmodule : mult_sequencer
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sequencer
// Description : Directed self-checking bench for mult_sequencer. Expected
//               products and latencies are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_cmp;
  int n_err;
  logic [63:0] last_exp;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands with start for exactly one rising edge.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called just after the accept edge. edges counts the accept edge as 1.
  // Optionally pulses start (with new operands) in loop iteration inject_at.
  task automatic wait_done(input int inject_at, input logic [31:0] ia, input logic [31:0] ib,
                           output int edges, output int bcnt, output bit seen);
    edges = 1;
    bcnt  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (i == inject_at) begin
        multiplicand = ia;
        multiplier   = ib;
        start        = 1'b1;
      end
      @(posedge clk);
      edges++;
      #1;
      start = 1'b0;
    end
  endtask

  task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int inject_at);
    int edges;
    int bcnt;
    bit seen;
    accept(a, b);
    chk({tag, "_held"}, product, last_exp);
    wait_done(inject_at, 32'h9, 32'h9, edges, bcnt, seen);
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(edges), 64'd35);
    chk({tag, "_busy"}, 64'(bcnt), 64'd34);
    chk({tag, "_prod"}, product, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    last_exp = exp;
  endtask

  initial begin
    int ndone;
    int first;
    int second;

    n_cmp        = 0;
    n_err        = 0;
    last_exp     = 64'd0;
    rst          = 1'b1;
    start        = 1'b1;
    multiplicand = 32'd3;
    multiplier   = 32'd3;

    // Reset overrides a pending start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_prod", product, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_release_busy", 64'(busy), 64'd0);

    full_op("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, -1);
    full_op("mn7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, -1);
    full_op("mmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
    full_op("mmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, -1);
    full_op("mzero", 32'd0, 32'hFFFF_FFFB, 64'd0, -1);

    // Start while busy is ignored; only one done pulse follows.
    full_op("ign", 32'd2, 32'd2, 64'd4, 9);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_no_extra_done", 64'(ndone), 64'd0);
    chk("ign_prod_stable", product, 64'd4);

    // Reset in the 12th ITER cycle aborts the multiply.
    accept(32'd5, 32'd5);
    repeat (13) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_prod", product, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    last_exp = 64'd0;
    full_op("m4x4", 32'd4, 32'd4, 64'd16, -1);

    // Start held high: back-to-back products every 35 cycles.
    @(negedge clk);
    multiplicand = 32'd3;
    multiplier   = 32'd7;
    start        = 1'b1;
    @(posedge clk);
    #1;
    multiplicand = 32'd10;
    multiplier   = 32'hFFFF_FFFD;
    ndone  = 0;
    first  = -1;
    second = -1;
    for (int i = 0; i < 120 && second < 0; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) begin
          first = i;
          chk("hold_p1", product, 64'd21);
        end else begin
          second = i;
          chk("hold_p2", product, 64'hFFFF_FFFF_FFFF_FFE2);
          start = 1'b0;
        end
      end
    end
    chk("hold_seen2", 64'(second >= 0), 64'd1);
    chk("hold_first_lat", 64'(first), 64'd34);
    chk("hold_gap", 64'(second - first), 64'd35);
    chk("hold_ndone", 64'(ndone), 64'd2);
    @(negedge clk);
    chk("hold_end_busy", 64'(busy), 64'd0);
    chk("hold_end_done", 64'(done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mult_sequencer
`default_nettype wire
